// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: packet width, hop-count field and the saturating hop decrement.
// No state; consumed by the channel buffers.
package noc_pkg;

    localparam int PKT_W   = 64;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;

    typedef logic [PKT_W-1:0] pkt_t;

    // A hop count already at zero stays at zero rather than wrapping.
    function automatic pkt_t hop_dec(input pkt_t p);
        pkt_t r;
        r = p;
        if (p[HOP_MSB:HOP_LSB] != 8'h00) begin
            r[HOP_MSB:HOP_LSB] = p[HOP_MSB:HOP_LSB] - 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/output_channel_buffer.sv
// Output channel buffer: circular FIFO of DEPTH packets, hop decrement applied on the way in.
// Latency: one cycle from accepted write to so/packet; no empty bypass.
// Backpressure: full stops the arbiter; a write arriving while full with no read is dropped and sets sticky overflow.
module output_channel_buffer
    import noc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter bit TO_PE = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PKT_W-1:0]         di,
    input  logic                     WE,
    output logic                     full,
    output logic [PKT_W-1:0]         packet,
    output logic                     so,
    input  logic                     ri,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    pkt_t            mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic            rd_en;
    logic            wr_vld;
    logic            wr_en;
    pkt_t            wr_dat;

    assign so        = (cnt_q != '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign occupancy = cnt_q;
    assign overflow  = ovf_q;
    assign packet    = so ? mem_q[rd_ptr_q] : '0;

    // An all-zero word means "no packet" and is never stored or counted as a drop.
    assign rd_en  = so & ri;
    assign wr_vld = WE & (di != '0);
    assign wr_en  = wr_vld & (~full | rd_en);
    assign wr_dat = TO_PE ? di : hop_dec(di);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (wr_en && !rd_en) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!wr_en && rd_en) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (wr_vld && !wr_en) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is left uncleared by reset; outputs mask it while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end

endmodule

// File: tb/tb_output_channel_buffer.sv
// Randomized and directed checks of output_channel_buffer against a queue-based reference model.
module tb_output_channel_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] di = '0;
    logic        we = 1'b0;
    logic        ri = 1'b0;

    logic        full0, so0, ovf0, full1, so1, ovf1;
    logic [63:0] pkt0, pkt1;
    logic [1:0]  occ0, occ1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] q[$];
    logic        ovf_m = 1'b0;

    output_channel_buffer #(.DEPTH(DEPTH), .TO_PE(1'b0)) dut (
        .clk(clk), .reset(rst_n), .di(di), .WE(we), .full(full0), .packet(pkt0),
        .so(so0), .ri(ri), .occupancy(occ0), .overflow(ovf0)
    );

    output_channel_buffer #(.DEPTH(DEPTH), .TO_PE(1'b1)) dut_pe (
        .clk(clk), .reset(rst_n), .di(di), .WE(we), .full(full1), .packet(pkt1),
        .so(so1), .ri(ri), .occupancy(occ1), .overflow(ovf1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] dec_hop(input logic [63:0] p);
        logic [63:0] r;
        int h;
        h = int'(p[55:48]);
        r = p;
        r[55:48] = (h == 0) ? 8'd0 : 8'(h - 1);
        return r;
    endfunction

    task automatic check_model();
        logic [63:0] head;
        head = (q.size() != 0) ? q[0] : 64'h0;
        check("so",        {63'h0, so0},   {63'h0, q.size() != 0});
        check("full",      {63'h0, full0}, {63'h0, q.size() == DEPTH});
        check("occupancy", {62'h0, occ0},  64'(q.size()));
        check("overflow",  {63'h0, ovf0},  {63'h0, ovf_m});
        check("packet",    pkt0, (q.size() != 0) ? dec_hop(head) : 64'h0);
        check("pe_packet", pkt1, head);
        check("pe_occ",    {62'h0, occ1},  64'(q.size()));
    endtask

    // One clock: drive inputs, check at negedge, retire the model at posedge.
    task automatic step(input logic w, input logic [63:0] d, input logic r);
        logic rd, wv, acc;
        we = w; di = d; ri = r;
        @(negedge clk);
        check_model();
        rd  = (q.size() != 0) && r;
        wv  = w && (d != 64'h0);
        acc = wv && ((q.size() < DEPTH) || rd);
        @(posedge clk);
        if (rd) void'(q.pop_front());
        if (acc) q.push_back(d);
        if (wv && !acc) ovf_m = 1'b1;
        #1;
        we = 1'b0; di = '0; ri = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_so",   {63'h0, so0},   64'h0);
        check("rst_full", {63'h0, full0}, 64'h0);
        check("rst_pkt",  pkt0,           64'h0);
        check("rst_occ",  {62'h0, occ0},  64'h0);
        check("rst_ovf",  {63'h0, ovf0},  64'h0);
        q.delete();
        ovf_m = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        check("init_so",  {63'h0, so0},  64'h0);
        check("init_pkt", pkt0,          64'h0);
        check("init_occ", {62'h0, occ0}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write, hop 3 -> 2, one cycle latency
        step(1'b1, 64'h0003_0000_0000_00AA, 1'b0);
        check("first_pkt", pkt0, 64'h0002_0000_0000_00AA);
        check("first_so",  {63'h0, so0}, 64'h1);
        check("first_occ", {62'h0, occ0}, 64'h1);
        step(1'b0, 64'h0, 1'b1);

        // Hop already zero stays zero; PE port keeps hop 5
        step(1'b1, 64'h0000_0000_0000_0011, 1'b0);
        check("hop_zero", pkt0, 64'h0000_0000_0000_0011);
        step(1'b1, 64'h0005_0000_0000_0022, 1'b1);
        check("pe_hop5",  pkt1, 64'h0005_0000_0000_0022);
        check("hop5_dec", pkt0, 64'h0004_0000_0000_0022);
        step(1'b0, 64'h0, 1'b1);

        // Fill, overflow on third write, then drain in order
        step(1'b1, 64'h0001_0000_0000_000A, 1'b0);
        step(1'b1, 64'h0001_0000_0000_000B, 1'b0);
        check("full_set", {63'h0, full0}, 64'h1);
        step(1'b1, 64'h0001_0000_0000_000C, 1'b0);
        check("ovf_set",  {63'h0, ovf0}, 64'h1);
        check("head_A",   pkt0, 64'h0000_0000_0000_000A);
        step(1'b0, 64'h0, 1'b1);
        check("head_B",   pkt0, 64'h0000_0000_0000_000B);
        step(1'b0, 64'h0, 1'b1);
        check("drained",  {63'h0, so0}, 64'h0);

        // Full with simultaneous write and read keeps occupancy at 2, no overflow
        pulse_reset();
        step(1'b1, 64'h0002_0000_0000_0001, 1'b0);
        step(1'b1, 64'h0002_0000_0000_0002, 1'b0);
        step(1'b1, 64'h0002_0000_0000_0003, 1'b1);
        check("wr_rd_occ", {62'h0, occ0}, 64'h2);
        check("wr_rd_ovf", {63'h0, ovf0}, 64'h0);
        check("wr_rd_hd",  pkt0, 64'h0001_0000_0000_0002);

        // Reset with two entries stored, then D is first out
        pulse_reset();
        step(1'b1, 64'h0004_0000_0000_000D, 1'b0);
        check("after_rst", pkt0, 64'h0003_0000_0000_000D);
        step(1'b0, 64'h0, 1'b1);

        // Zero packet ignored, ri toggling while empty has no effect
        step(1'b1, 64'h0, 1'b1);
        check("zero_occ", {62'h0, occ0}, 64'h0);
        check("zero_ovf", {63'h0, ovf0}, 64'h0);
        step(1'b0, 64'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) d = 64'h0;
            if ($urandom_range(0, 3) == 0) d[55:48] = 8'(($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) pulse_reset();
            step(1'($urandom_range(0, 2) != 0), d, 1'($urandom_range(0, 1)));
        end
        step(1'b0, 64'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/output_channel_buffer.md
OUTPUT_CHANNEL_BUFFER -- requirements
Module: output_channel_buffer

Interface
REQ-001 Parameter DEPTH, default 2: buffer entries; power of two, at least 2.
REQ-002 Parameter TO_PE, default 0: 1 when this port feeds the local PE, which disables the hop update.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 di  input  64  packet from the switch/crossbar; hop count in [55:48].
REQ-006 WE  input  1  write strobe from the granted input channel.
REQ-007 full  output  1  backpressure to the arbiter; no grant is to be issued while high.
REQ-008 packet  output  64  head-of-queue packet presented downstream.
REQ-009 so  output  1  send-out valid; a packet is offered downstream.
REQ-010 ri  input  1  ready-in from the downstream input channel buffer.
REQ-011 occupancy  output  $clog2(DEPTH)+1  number of stored packets.
REQ-012 overflow  output  1  sticky flag: a write was dropped.

Function
REQ-013 Storage shall be a circular FIFO of DEPTH 64-bit entries, with read/write pointers wrapping modulo DEPTH.
REQ-014 A write shall be accepted when WE=1, di!=64'h0, and (occupancy<DEPTH or a read occurs in the same cycle).
REQ-015 WE=1 with di==64'h0 shall be ignored: no storage, no overflow (zero means "no packet").
REQ-016 With TO_PE=0, the stored entry shall equal di with [55:48] replaced by di[55:48]-1, saturating at 8'h00.
REQ-017 With TO_PE=1, the stored entry shall equal di unchanged.
REQ-018 A read (transfer) shall occur exactly when so=1 and ri=1 at a rising edge; the head entry is then removed.
REQ-019 so shall equal (occupancy!=0), and full shall equal (occupancy==DEPTH); both are combinational from registered state.
REQ-020 packet shall be the head entry when so=1, else 64'h0.
REQ-021 Latency: a packet written at edge N shall appear on packet/so after edge N, i.e. one cycle.
REQ-022 Packet order shall be strictly first-in first-out, with no drop or duplication of accepted writes.
REQ-023 Simultaneous accepted write and read shall leave occupancy unchanged.
REQ-024 When empty, a simultaneous write is not visible the same cycle; there is no bypass.
REQ-025 A write that is not accepted because the FIFO is full with no read shall be dropped and shall set overflow to 1 until reset.
REQ-026 ri toggling while so=0 shall have no effect.

Reset
REQ-027 While reset=0, pointers and occupancy shall be 0, overflow 0, so 0, full 0, and packet 64'h0, asynchronously.
REQ-028 Storage contents need not be cleared; outputs shall not expose them while empty.
REQ-029 Reset asserted mid-transfer shall abort it; after release, the first accepted write shall be the first packet out.

Structure
REQ-030 Shared package noc_pkg shall hold: PKT_W=64, HOP_MSB=55, HOP_LSB=48, a packet typedef, and the saturating hop-decrement function.
REQ-031 No sub-module: FIFO storage and control shall be implemented inline; the input-side hop check remains in the input channel buffer.

Verification
REQ-032 Reset, then WE=1 with di=64'h0003_0000_0000_00AA for 1 cycle, ri=0 -> next cycle so=1, packet=64'h0002_0000_0000_00AA, occupancy=1.
REQ-033 TO_PE=0, di with hop 8'h00 -> stored hop stays 8'h00; TO_PE=1, hop 8'h05 -> packet hop 8'h05.
REQ-034 Write packets A, B with ri=0 -> full=1; third write C -> dropped, overflow=1; then ri=1 -> A, then B out, then so=0.
REQ-035 full, with WE=1 and ri=1 in the same cycle -> one packet out, new one accepted, occupancy stays 2, overflow stays 0.
REQ-036 WE=1, di=64'h0 -> occupancy unchanged, so=0, overflow=0.
REQ-037 Reset pulse with 2 entries stored -> so=0, full=0, packet=0 immediately, without waiting for a clock; subsequent write D -> D is the first packet out.
